// File: rtl/my_seg_rx.sv
// Seven-segment display snooper: recovers the two-digit seconds value from a
// multiplexed segment bus (AN = segments, CA = digit select).
module my_seg_rx #(
  parameter int CLK_FREQ    = 125_000_000,
  parameter int STABLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] AN,
  input  logic       CA,
  output logic [3:0] Digit_10s,
  output logic [3:0] Digit_1s,
  output logic [5:0] Time_sec,
  output logic       valid,
  output logic       lock,
  output logic       err
);

  // A TIMEOUT_CYC of zero falls back to a 20 ms window derived from CLK_FREQ.
  localparam int TO_LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC : (CLK_FREQ / 50);
  localparam int STB_W    = $clog2(STABLE_CYC + 1);
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYC);
  localparam logic [STB_W-1:0] STB_HIT = STB_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TO_LIMIT);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GOT_TENS = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Synchronizer and change detection
  logic [6:0]       an_s1_q, an_s2_q;
  logic             ca_s1_q, ca_s2_q;
  logic [7:0]       seg_prev_q;
  logic [7:0]       seg_now;
  logic             seg_chg;
  logic             ca_edge;

  // Counters and capture bookkeeping
  logic [STB_W-1:0] stab_q, stab_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             taken_q, taken_d;
  logic             capture;
  logic             cap_use;
  logic             timeout;

  // Decoded capture
  logic [4:0]       dec;
  logic [3:0]       cap_digit;
  logic             cap_tens;
  logic             cap_legal;

  // Pending tens digit and published outputs
  logic [3:0]       pend_q, pend_d;
  logic             pend_ok_q, pend_ok_d;
  logic [3:0]       d10_q, d10_d;
  logic [3:0]       d1_q, d1_d;
  logic [5:0]       time_q, time_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             publish;
  logic [5:0]       tens6;
  logic [5:0]       new_time;

  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0;
    unique case (p)
      7'h7E: r = {1'b1, 4'd0};
      7'h30: r = {1'b1, 4'd1};
      7'h6D: r = {1'b1, 4'd2};
      7'h79: r = {1'b1, 4'd3};
      7'h33: r = {1'b1, 4'd4};
      7'h5B: r = {1'b1, 4'd5};
      7'h5F: r = {1'b1, 4'd6};
      7'h70: r = {1'b1, 4'd7};
      7'h7F: r = {1'b1, 4'd8};
      7'h7B: r = {1'b1, 4'd9};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      ca_s1_q    <= 1'b0;
      ca_s2_q    <= 1'b0;
      seg_prev_q <= '0;
      stab_q     <= '0;
      to_q       <= '0;
      taken_q    <= 1'b0;
    end else begin
      an_s1_q    <= AN;
      an_s2_q    <= an_s1_q;
      ca_s1_q    <= CA;
      ca_s2_q    <= ca_s1_q;
      seg_prev_q <= seg_now;
      stab_q     <= stab_d;
      to_q       <= to_d;
      taken_q    <= taken_d;
    end
  end

  always_comb begin
    seg_now = {ca_s2_q, an_s2_q};
    seg_chg = (seg_now != seg_prev_q);
    ca_edge = (ca_s2_q != seg_prev_q[7]);

    stab_d = stab_q;
    if (seg_chg) begin
      stab_d = '0;
    end else if (stab_q != STB_MAX) begin
      stab_d = stab_q + STB_W'(1);
    end

    to_d = to_q;
    if (ca_edge) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end

    // Capture fires on the cycle the counter reaches the limit, once per CA phase.
    capture = !seg_chg && !taken_q && (stab_q == STB_HIT);
    taken_d = ca_edge ? 1'b0 : (taken_q | capture);

    timeout = (state_q == LOCKED) && (to_d == TO_MAX);
    cap_use = capture && !timeout;

    dec       = seg_decode(an_s2_q);
    cap_digit = dec[3:0];
    cap_tens  = ca_s2_q;
    cap_legal = dec[4] && !(cap_tens && (cap_digit > 4'd5));
  end

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state (a timeout outranks any capture in the same cycle)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (capture && cap_legal && cap_tens) begin
          state_d = GOT_TENS;
        end
      end
      GOT_TENS: begin
        if (capture) begin
          state_d = (cap_legal && !cap_tens) ? LOCKED : HUNT;
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d = HUNT;
        end else if (capture && !cap_legal) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // FSM: outputs and datapath
  always_comb begin
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    d10_d     = d10_q;
    d1_d      = d1_q;
    time_d    = time_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    publish   = 1'b0;
    tens6     = {2'b00, pend_q};
    new_time  = (tens6 << 3) + (tens6 << 1) + {2'b00, cap_digit};

    if (cap_use && !cap_legal) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      HUNT: begin
        if (cap_use && cap_legal && cap_tens) begin
          pend_d    = cap_digit;
          pend_ok_d = 1'b1;
        end
      end
      GOT_TENS: begin
        if (cap_use && cap_legal && !cap_tens) begin
          publish = 1'b1;
        end
      end
      LOCKED: begin
        if (cap_use && cap_legal) begin
          if (cap_tens) begin
            pend_d    = cap_digit;
            pend_ok_d = 1'b1;
          end else if (pend_ok_q) begin
            publish = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (publish) begin
      pend_ok_d = 1'b0;
      d10_d     = pend_q;
      d1_d      = cap_digit;
      time_d    = new_time;
      // The first publish of a lock always announces itself, even if unchanged.
      valid_d   = (state_q == GOT_TENS) || (new_time != time_q);
    end

    if (state_d == HUNT) begin
      pend_ok_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      d10_q     <= '0;
      d1_q      <= '0;
      time_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      d10_q     <= d10_d;
      d1_q      <= d1_d;
      time_q    <= time_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // valid is a one-cycle strobe with no ready: a consumer must take Time_sec
  // in the cycle valid is high; the value itself stays put until the next publish.
  assign Digit_10s = d10_q;
  assign Digit_1s  = d1_q;
  assign Time_sec  = time_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign lock      = (state_q == LOCKED);

endmodule
